param_stack: RTL and testbench
==============================

Name: param_stack

Overview:
- Parametrised hardware LIFO stack for the stack-machine datapath. Successor to the fixed 16-bit load/push/pop stack.
- Generalised in width and depth. Adds occupancy count, full/empty flags, sticky overflow/underflow error flags, and dup/reduce operations.
- Exposes top-of-stack and next-of-stack so the ALU can consume two operands and write one result back in a single cycle.

Parameters:
- WIDTH, 16, data width of each entry in bits.
- DEPTH, 8, number of entries; legal range is 2 or more.
- CW, $clog2(DEPTH+1), width of the count output; derived, never overridden.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- load  in  1  write d into the stack (meaning per command table).
- push  in  1  grow the stack.
- pop  in  1  shrink the stack.
- d  in  WIDTH  write data.
- clr_err  in  1  clear the sticky ovf/unf flags.
- qtop  out  WIDTH  entry 0 (top); 0 when count==0.
- qnext  out  WIDTH  entry 1; 0 when count<2.
- count  out  CW  number of valid entries, 0..DEPTH.
- empty  out  1  count==0.
- full  out  1  count==DEPTH.
- ovf  out  1  sticky overflow flag.
- unf  out  1  sticky underflow flag.

Behaviour:
- Reset (sampled at a rising edge of clk with reset=1) has priority over everything.
  - count=0, ovf=0, unf=0, all storage cleared.
  - Resulting outputs: qtop=0, qnext=0, empty=1, full=0.
  - Reset in the middle of any command sequence discards the whole stack.
- All state updates occur on the rising edge. qtop, qnext, count, empty and full are decoded combinationally from registered state, so a command's result is visible immediately after the edge that executes it (1-cycle latency). No combinational path from inputs to outputs.
- Command decode on {load,push,pop}:
  - 000: idle, no change.
  - 110 PUSH: d becomes the new top; old entries shift down; count+1.
    - If full: rejected, state unchanged, ovf<=1.
  - 100 REPLACE: top<=d, count unchanged.
    - If empty: acts as PUSH (count becomes 1).
  - 001 POP: discard top; entry1 becomes top; count-1.
    - If empty: no change, unf<=1.
  - 101 / 111 REDUCE (push ignored): discard top, overwrite the new top with d, count-1. This implements the binary ALU writeback in one cycle.
    - If count<2: no change, unf<=1.
  - 010 DUP: push a copy of qtop; count+1.
    - If empty: unf<=1, no change.
    - If full: ovf<=1, no change.
    - Check empty first.
  - 011: no-op, unless STACK_SWAP_EN is defined.
- Entries below count hold don't-care contents internally, but qtop and qnext must read 0 when their entry is invalid.
- Error flags:
  - ovf and unf are sticky and never auto-clear.
  - clr_err=1 clears both at the edge.
  - If an error occurs in the same cycle as clr_err, set wins and the flag reads 1.
  - A rejected command never alters data or count.
- Wrap-around: count saturates by rejection. It never wraps past DEPTH or below 0.

Optional Feature:
- Macro: STACK_SWAP_EN.
- Defined: command 011 is SWAP.
  - Exchanges entry0 and entry1; count unchanged.
  - If count<2: no change, unf<=1.
- Undefined: 011 is a no-op and sets no flags. No swap logic is synthesised.

Test Plan:
- Reset, then push 1234, 5678, 9ABC, DEF0 with WIDTH=16, DEPTH=4 -> after the 4th edge: qtop=DEF0, qnext=9ABC, count=4, full=1, ovf=0.
- At full, PUSH d=AAAA -> state unchanged (qtop=DEF0, count=4), ovf=1. Then assert clr_err for 1 cycle -> ovf=0.
- From 4 entries, POP x5 -> qtop sequence 9ABC, 5678, 1234, 0. count reaches 0, empty=1. The 5th POP sets unf=1 with count staying 0.
- With 1234, 5678 on the stack, REDUCE d=68AC -> count=1, qtop=68AC, qnext=0. A second REDUCE -> unf=1, qtop stays 68AC.
- Empty stack: REPLACE d=0042 -> count=1, qtop=0042. Then DUP -> count=2, qtop=qnext=0042. Then reset mid-sequence -> count=0, qtop=0, flags 0.
- STACK_SWAP_EN defined, stack holds 1111 (top) and 2222 -> 011 gives qtop=2222, qnext=1111. With one entry -> unf=1. Macro undefined -> 011 leaves everything unchanged.

Source files
------------

// File: rtl/param_stack.sv
// param_stack: parametrised LIFO stack with top/next taps, count, full/empty and sticky ovf/unf flags
// Ports: clk, reset (sync, active-high); load/push/pop command, d write data, clr_err clears flags;
//        qtop/qnext top two entries (0 when invalid), count, empty, full, ovf, unf.
// Optional: define STACK_SWAP_EN to make command 011 swap the top two entries.
module param_stack #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] d,
  input  logic             clr_err,
  output logic [WIDTH-1:0] qtop,
  output logic [WIDTH-1:0] qnext,
  output logic [CW-1:0]    count,
  output logic             empty,
  output logic             full,
  output logic             ovf,
  output logic             unf
);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [CW-1:0] cnt_q, cnt_d;
  logic ovf_q, ovf_d, unf_q, unf_d;
  logic grow, shrink, wr_top, lt2;
  logic [WIDTH-1:0] top_val;
  logic [2:0] cmd;
`ifdef STACK_SWAP_EN
  logic swap;
`endif
  assign cmd   = {load, push, pop};
  assign empty = cnt_q == '0;
  assign full  = cnt_q == CW'(DEPTH);
  assign lt2   = cnt_q < CW'(2);
  assign count = cnt_q;
  assign qtop  = empty ? '0 : mem_q[0];
  assign qnext = lt2 ? '0 : mem_q[1];
  assign ovf   = ovf_q;
  assign unf   = unf_q;
  // DUP writes the current top back as the new top; every other write uses d
  assign top_val = (cmd == 3'b010) ? mem_q[0] : d;
  always_comb begin
    grow   = 1'b0;
    shrink = 1'b0;
    wr_top = 1'b0;
    ovf_d  = ovf_q & ~clr_err;
    unf_d  = unf_q & ~clr_err;
`ifdef STACK_SWAP_EN
    swap   = 1'b0;
`endif
    case (cmd)
      3'b110: if (full) ovf_d = 1'b1; else {grow, wr_top} = 2'b11;
      3'b100: {grow, wr_top} = {empty, 1'b1};
      3'b001: if (empty) unf_d = 1'b1; else shrink = 1'b1;
      3'b101, 3'b111: if (lt2) unf_d = 1'b1; else {shrink, wr_top} = 2'b11;
      3'b010: if (empty) unf_d = 1'b1; else if (full) ovf_d = 1'b1; else {grow, wr_top} = 2'b11;
`ifdef STACK_SWAP_EN
      3'b011: if (lt2) unf_d = 1'b1; else swap = 1'b1;
`endif
      default: ;
    endcase
    cnt_d = grow ? cnt_q + 1'b1 : shrink ? cnt_q - 1'b1 : cnt_q;
    mem_d[0] = wr_top ? top_val : shrink ? mem_q[1] : mem_q[0];
    for (int i = 1; i < DEPTH - 1; i++)
      mem_d[i] = grow ? mem_q[i-1] : shrink ? mem_q[i+1] : mem_q[i];
    mem_d[DEPTH-1] = grow ? mem_q[DEPTH-2] : shrink ? '0 : mem_q[DEPTH-1];
`ifdef STACK_SWAP_EN
    if (swap) begin
      mem_d[0] = mem_q[1];
      mem_d[1] = mem_q[0];
    end
`endif
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
      mem_q <= mem_d;
    end
  end
endmodule

// File: tb/tb_param_stack.sv
// tb_param_stack: table-driven and model-driven checks of param_stack (WIDTH=16, DEPTH=4)
module tb_param_stack;
  localparam int W = 16;
  localparam int D = 4;
  logic clk = 1'b0;
  logic reset = 1'b0, load = 1'b0, push = 1'b0, pop = 1'b0, clr_err = 1'b0;
  logic [W-1:0] d = '0;
  logic [W-1:0] qtop, qnext;
  logic [2:0] count;
  logic empty, full, ovf, unf;
  typedef logic [38:0] obs_t;
  typedef struct packed {
    logic rst, ld, pu, po, clr;
    logic [W-1:0] dv;
    obs_t exp;
  } vec_t;
  vec_t vecs[$];
  obs_t sb[$];
  logic [W-1:0] m[$];
  logic mo, mu;
  int n_chk = 0, n_fail = 0, stp = 0;

  param_stack #(.WIDTH(W), .DEPTH(D)) dut (
    .clk(clk), .reset(reset), .load(load), .push(push), .pop(pop), .d(d), .clr_err(clr_err),
    .qtop(qtop), .qnext(qnext), .count(count), .empty(empty), .full(full), .ovf(ovf), .unf(unf)
  );

  always #5 clk = ~clk;

  function automatic void v(logic rst, logic ld, logic pu, logic po, logic clr, logic [W-1:0] dv,
                             logic [W-1:0] qt, logic [W-1:0] qn, logic [2:0] c,
                             logic e, logic f, logic o, logic u);
    vecs.push_back('{rst, ld, pu, po, clr, dv, {qt, qn, c, e, f, o, u}});
  endfunction

  function automatic obs_t model_obs();
    return {m.size() > 0 ? m[0] : 16'h0, m.size() > 1 ? m[1] : 16'h0, 3'(m.size()),
            m.size() == 0, m.size() == D, mo, mu};
  endfunction

  task automatic check();
    obs_t a, e;
    a = {qtop, qnext, count, empty, full, ovf, unf};
    n_chk++;
    if (sb.size() == 0) begin
      n_fail++;
      $display("FAIL step %0d: scoreboard empty, got %h", stp, a);
    end else begin
      e = sb.pop_front();
      if (a !== e) begin
        n_fail++;
        $display("FAIL step %0d: got qtop=%h qnext=%h count=%0d empty=%b full=%b ovf=%b unf=%b, expected qtop=%h qnext=%h count=%0d empty=%b full=%b ovf=%b unf=%b",
                 stp, a[38:23], a[22:7], a[6:4], a[3], a[2], a[1], a[0],
                 e[38:23], e[22:7], e[6:4], e[3], e[2], e[1], e[0]);
      end
    end
  endtask

  task automatic step(logic rst, logic ld, logic pu, logic po, logic clr, logic [W-1:0] dv, obs_t exp);
    @(negedge clk);
    reset = rst; load = ld; push = pu; pop = po; clr_err = clr; d = dv;
    sb.push_back(exp);
    @(posedge clk);
    #1;
    check();
    stp++;
  endtask

  initial begin
    v(1,0,0,0,0,16'h0,    16'h0,16'h0,0,1,0,0,0);
    v(0,1,1,0,0,16'h1234, 16'h1234,16'h0,1,0,0,0,0);
    v(0,1,1,0,0,16'h5678, 16'h5678,16'h1234,2,0,0,0,0);
    v(0,1,1,0,0,16'h9ABC, 16'h9ABC,16'h5678,3,0,0,0,0);
    v(0,1,1,0,0,16'hDEF0, 16'hDEF0,16'h9ABC,4,0,1,0,0);
    v(0,1,1,0,0,16'hAAAA, 16'hDEF0,16'h9ABC,4,0,1,1,0);
    v(0,0,0,0,0,16'h0,    16'hDEF0,16'h9ABC,4,0,1,1,0);
    v(0,0,0,0,1,16'h0,    16'hDEF0,16'h9ABC,4,0,1,0,0);
    v(0,0,1,0,0,16'h0,    16'hDEF0,16'h9ABC,4,0,1,1,0);
    v(0,1,1,0,1,16'hAAAA, 16'hDEF0,16'h9ABC,4,0,1,1,0);
    v(0,0,0,0,1,16'h0,    16'hDEF0,16'h9ABC,4,0,1,0,0);
    v(0,0,0,1,0,16'h0,    16'h9ABC,16'h5678,3,0,0,0,0);
    v(0,0,0,1,0,16'h0,    16'h5678,16'h1234,2,0,0,0,0);
    v(0,0,0,1,0,16'h0,    16'h1234,16'h0,1,0,0,0,0);
    v(0,0,0,1,0,16'h0,    16'h0,16'h0,0,1,0,0,0);
    v(0,0,0,1,0,16'h0,    16'h0,16'h0,0,1,0,0,1);
    v(0,0,0,0,1,16'h0,    16'h0,16'h0,0,1,0,0,0);
    v(0,0,1,0,0,16'h0,    16'h0,16'h0,0,1,0,0,1);
    v(0,0,0,0,1,16'h0,    16'h0,16'h0,0,1,0,0,0);
    v(0,1,1,0,0,16'h1234, 16'h1234,16'h0,1,0,0,0,0);
    v(0,1,1,0,0,16'h5678, 16'h5678,16'h1234,2,0,0,0,0);
    v(0,1,0,1,0,16'h68AC, 16'h68AC,16'h0,1,0,0,0,0);
    v(0,1,1,1,0,16'hFFFF, 16'h68AC,16'h0,1,0,0,0,1);
    v(0,0,0,0,1,16'h0,    16'h68AC,16'h0,1,0,0,0,0);
    v(0,0,0,1,0,16'h0,    16'h0,16'h0,0,1,0,0,0);
    v(0,1,0,0,0,16'h0042, 16'h0042,16'h0,1,0,0,0,0);
    v(0,1,0,0,0,16'h0043, 16'h0043,16'h0,1,0,0,0,0);
    v(0,0,1,0,0,16'h0,    16'h0043,16'h0043,2,0,0,0,0);
    v(0,1,1,1,0,16'h0001, 16'h0001,16'h0,1,0,0,0,0);
    v(0,1,1,1,0,16'h0002, 16'h0001,16'h0,1,0,0,0,1);
    v(1,1,1,0,0,16'h7777, 16'h0,16'h0,0,1,0,0,0);
    v(0,1,1,0,0,16'h2222, 16'h2222,16'h0,1,0,0,0,0);
`ifdef STACK_SWAP_EN
    v(0,0,1,1,0,16'h0,    16'h2222,16'h0,1,0,0,0,1);
    v(0,0,0,0,1,16'h0,    16'h2222,16'h0,1,0,0,0,0);
    v(0,1,1,0,0,16'h1111, 16'h1111,16'h2222,2,0,0,0,0);
    v(0,0,1,1,0,16'h0,    16'h2222,16'h1111,2,0,0,0,0);
    v(0,0,1,1,0,16'h0,    16'h1111,16'h2222,2,0,0,0,0);
`else
    v(0,0,1,1,0,16'h0,    16'h2222,16'h0,1,0,0,0,0);
    v(0,1,1,0,0,16'h1111, 16'h1111,16'h2222,2,0,0,0,0);
    v(0,0,1,1,0,16'h5555, 16'h1111,16'h2222,2,0,0,0,0);
`endif
    v(1,0,0,0,0,16'h0,    16'h0,16'h0,0,1,0,0,0);

    foreach (vecs[i])
      step(vecs[i].rst, vecs[i].ld, vecs[i].pu, vecs[i].po, vecs[i].clr, vecs[i].dv, vecs[i].exp);

    // LIFO model: overfill by two, then overdrain by two
    m.delete();
    mo = 1'b0;
    mu = 1'b0;
    for (int i = 0; i < D + 2; i++) begin
      logic [W-1:0] val;
      val = 16'h1000 + 16'(i * 16'h0111) + 16'($urandom_range(0, 15));
      if (m.size() < D) m.push_front(val); else mo = 1'b1;
      step(0, 1, 1, 0, 0, val, model_obs());
    end
    for (int i = 0; i < D + 2; i++) begin
      if (m.size() > 0) void'(m.pop_front()); else mu = 1'b1;
      step(0, 0, 0, 1, 0, 16'h0, model_obs());
    end
    mo = 1'b0;
    mu = 1'b0;
    step(0, 0, 0, 0, 1, 16'h0, model_obs());

    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard drain: %0d entries left, expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
